// File: rtl/printf_line_arbiter.sv
// printf_line_arbiter
//   Shares one printf character sink between N_REQ requesters so that text
//   lines from different cores never interleave. Each requester fills a
//   private FIFO; the arbiter grants the sink round-robin and drains a whole
//   line (through NEWLINE) per grant. A FIFO that fills up without a newline
//   is flushed as a BUF_DEPTH-byte block so its writer cannot deadlock.
//
// Ports
//   clk         : clock (single domain)
//   arst        : asynchronous active-high reset; discards all buffered bytes
//   char_valid  : [N_REQ]   per-requester byte valid
//   char_data   : [N_REQ*8] per-requester byte, requester i on [8i+7:8i]
//   char_ready  : [N_REQ]   per-requester FIFO not full (registered state only)
//   out_valid   : byte valid toward the sink
//   out_data    : byte toward the sink
//   out_id      : index of the granted requester
//   out_last    : this byte ends the current grant
//   out_ready   : sink accepts the byte
//   busy        : a grant is being drained
module printf_line_arbiter #(
  parameter int         N_REQ     = 4,
  parameter int         BUF_DEPTH = 16,
  parameter logic [7:0] NEWLINE   = 8'h0A
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_REQ-1:0]         char_valid,
  input  logic [N_REQ*8-1:0]       char_data,
  output logic [N_REQ-1:0]         char_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(N_REQ);

  localparam logic [CW-1:0] FULL     = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] LAST_BLK = CW'(BUF_DEPTH - 1);

  typedef enum logic { IDLE, DRAIN } state_t;
  typedef enum logic { MODE_LINE, MODE_BLOCK } mode_t;

  state_t        state, state_next;
  mode_t         mode, mode_next;
  logic [IW-1:0] grant, grant_next;
  logic [IW-1:0] rr_ptr, rr_next;
  logic [CW-1:0] sent_cnt, sent_next;

  // Per-requester FIFO storage and bookkeeping
  logic [7:0]    mem    [N_REQ][BUF_DEPTH];
  logic [AW-1:0] wr_ptr [N_REQ];
  logic [AW-1:0] rd_ptr [N_REQ];
  logic [CW-1:0] cnt    [N_REQ];
  logic [CW-1:0] nl     [N_REQ];

  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop_sel;
  logic [N_REQ-1:0] nl_inc;
  logic [N_REQ-1:0] nl_dec;
  logic [N_REQ-1:0] has_line;
  logic [N_REQ-1:0] eligible;

  logic [7:0]    head;
  logic          pop;
  logic          found;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;

  // ---------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      char_ready[i] = (cnt[i] != FULL);
      push[i]       = char_valid[i] && char_ready[i];
      nl_inc[i]     = push[i] && (char_data[8*i +: 8] == NEWLINE);
      has_line[i]   = (nl[i] != '0);
      eligible[i]   = has_line[i] || (cnt[i] == FULL);
    end
  end

  assign head = mem[grant][rd_ptr[grant]];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pop_sel[i] = pop && (grant == IW'(i));
      nl_dec[i]  = pop_sel[i] && (head == NEWLINE);
    end
  end

  // ---------------------------------------------------------------------------
  // Sink-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    out_last  = 1'b0;
    pop       = 1'b0;
    if (state == DRAIN) begin
      out_id    = grant;
      out_valid = (cnt[grant] != '0);
      if (out_valid) begin
        out_data = head;
        out_last = (mode == MODE_LINE) ? (head == NEWLINE) : (sent_cnt == LAST_BLK);
        pop      = out_ready;
      end
    end
  end

  assign busy = (state == DRAIN);

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    grant_next = grant;
    mode_next  = mode;
    rr_next    = rr_ptr;
    sent_next  = sent_cnt;
    found      = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    case (state)
      IDLE: begin
        // Scan from rr_ptr upward with wrap at N_REQ (N_REQ need not be a power of 2)
        for (int unsigned k = 0; k < N_REQ; k++) begin
          scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
          if (scan_sum >= (IW+1)'(N_REQ)) begin
            scan_sum = scan_sum - (IW+1)'(N_REQ);
          end
          scan_idx = scan_sum[IW-1:0];
          if (!found && eligible[scan_idx]) begin
            found      = 1'b1;
            grant_next = scan_idx;
            mode_next  = has_line[scan_idx] ? MODE_LINE : MODE_BLOCK;
          end
        end
        if (found) begin
          state_next = DRAIN;
          sent_next  = '0;
        end
      end
      DRAIN: begin
        if (pop) begin
          if (out_last) begin
            state_next = IDLE;
            rr_next    = (grant == IW'(N_REQ - 1)) ? '0 : grant + IW'(1);
          end else if (mode == MODE_BLOCK) begin
            sent_next = sent_cnt + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      mode     <= MODE_LINE;
      grant    <= '0;
      rr_ptr   <= '0;
      sent_cnt <= '0;
    end else begin
      state    <= state_next;
      mode     <= mode_next;
      grant    <= grant_next;
      rr_ptr   <= rr_next;
      sent_cnt <= sent_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO state; storage itself needs no reset since pointers/counts gate it
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= char_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        nl[i]     <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop_sel[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        case ({push[i], pop_sel[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
        case ({nl_inc[i], nl_dec[i]})
          2'b10:   nl[i] <= nl[i] + CW'(1);
          2'b01:   nl[i] <= nl[i] - CW'(1);
          default: nl[i] <= nl[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_printf_line_arbiter.sv
// Testbench for printf_line_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_printf_line_arbiter;

  localparam int         N     = 4;
  localparam int         DEPTH = 16;
  localparam int         IW    = 2;
  localparam logic [7:0] NL    = 8'h0A;

  logic              clk = 1'b0;
  logic              arst;
  logic [N-1:0]      char_valid;
  logic [N*8-1:0]    char_data;
  logic [N-1:0]      char_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [IW-1:0]     out_id;
  logic              out_last;
  logic              out_ready;
  logic              busy;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  printf_line_arbiter #(
    .N_REQ    (N),
    .BUF_DEPTH(DEPTH),
    .NEWLINE  (NL)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model: one byte queue per requester plus grant bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0] mq [N][$];
  bit         m_busy;
  bit         m_line;
  int         m_grant;
  int         m_rr;
  int         m_sent;

  logic          e_busy, e_valid, e_last;
  logic [IW-1:0] e_id;
  logic [7:0]    e_data;
  logic [N-1:0]  e_ready;

  function automatic bit has_nl(int r);
    for (int k = 0; k < mq[r].size(); k++) begin
      if (mq[r][k] == NL) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_busy  = 1'b0;
    m_line  = 1'b1;
    m_grant = 0;
    m_rr    = 0;
    m_sent  = 0;
  endtask

  task automatic model_outputs();
    e_busy  = m_busy;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_id    = '0;
    e_data  = '0;
    if (m_busy) begin
      e_id = IW'(m_grant);
      if (mq[m_grant].size() > 0) begin
        e_valid = 1'b1;
        e_data  = mq[m_grant][0];
        e_last  = m_line ? (e_data == NL) : (m_sent == DEPTH - 1);
      end
    end
    for (int i = 0; i < N; i++) e_ready[i] = (mq[i].size() < DEPTH);
  endtask

  task automatic model_edge();
    bit acc [N];
    bit found;
    int r;
    if (arst) begin
      model_reset();
      return;
    end
    model_outputs();
    for (int i = 0; i < N; i++) acc[i] = char_valid[i] && (mq[i].size() < DEPTH);
    if (m_busy) begin
      if (e_valid && out_ready) begin
        void'(mq[m_grant].pop_front());
        if (e_last) begin
          m_busy = 1'b0;
          m_rr   = (m_grant + 1) % N;
        end else if (!m_line) begin
          m_sent++;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        r = (m_rr + k) % N;
        if (!found && (has_nl(r) || mq[r].size() == DEPTH)) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_grant = r;
          m_line  = has_nl(r);
          m_sent  = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) mq[i].push_back(char_data[8*i +: 8]);
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {busy, out_valid, out_last, out_id, out_data, char_ready};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {e_busy, e_valid, e_last, e_id, e_data, e_ready};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking here)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    char_valid = '0;
    char_data  = '0;
  endtask

  task automatic set_char(input int r, input logic [7:0] b);
    char_valid[r]      = 1'b1;
    char_data[8*r +: 8] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    arst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    model_reset();
    #2;
    compared++;
    if ({busy, out_valid, out_last, out_id, out_data} !== 13'h0) begin
      failed++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, out_valid, out_last, out_id, out_data});
    end
    compared++;
    if (char_ready !== '1) begin
      failed++;
      $display("FAIL reset_ready got=%b exp=1111", char_ready);
    end
    @(negedge clk);
    arst = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    compared++;
    if ({busy, out_valid, out_last, out_id, out_data, char_ready} !== 17'h0000F) begin
      failed++;
      $display("FAIL reset_idle got=%h exp=0000f", dut_vec());
    end
  endtask

  task automatic test_hi_line();
    logic [7:0] msg [3] = '{8'h68, 8'h69, 8'h0A};
    logic [7:0] got [$];
    logic [IW-1:0] gid [$];
    logic glast [$];
    int valid_cyc = -1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c < 3) set_char(0, msg[c]);
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL hi_line cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && valid_cyc < 0) valid_cyc = c;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        gid.push_back(out_id);
        glast.push_back(out_last);
      end
      tick();
    end
    // newline driven in cycle 2 -> eligible after that edge -> grant at next -> valid in cycle 4
    compared++;
    if (valid_cyc != 4) begin
      failed++;
      $display("FAIL hi_latency got=%0d exp=4", valid_cyc);
    end
    compared++;
    if (got.size() != 3) begin
      failed++;
      $display("FAIL hi_count got=%0d exp=3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if ({got[i], gid[i], glast[i]} !== {msg[i], 2'd0, (i == 2)}) begin
          failed++;
          $display("FAIL hi_byte%0d got=%h/%0d/%0d exp=%h/0/%0d", i, got[i], gid[i], glast[i], msg[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int first_cyc [$];
    logic [IW-1:0] lids [$];
    bit new_line = 1'b1;
    int first_id = -1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      for (int r = 0; r < N; r++) begin
        if (c == 0) set_char(r, 8'h41);
        if (c == 1) set_char(r, NL);
      end
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL rr cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && out_ready) begin
        if (new_line) first_cyc.push_back(c);
        new_line = out_last;
        if (out_last) lids.push_back(out_id);
      end
      tick();
    end
    compared++;
    if (lids.size() != 4) begin
      failed++;
      $display("FAIL rr_lines got=%0d exp=4", lids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (lids[i] !== IW'(i)) begin
          failed++;
          $display("FAIL rr_order%0d got=%0d exp=%0d", i, lids[i], i);
        end
      end
      for (int i = 1; i < 4; i++) begin
        compared++;
        if (first_cyc[i] - first_cyc[i-1] != 3) begin
          failed++;
          $display("FAIL rr_gap%0d got=%0d exp=3", i, first_cyc[i] - first_cyc[i-1]);
        end
      end
    end
    // pointer wrapped to 0: requester 0 must beat requester 3
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c == 0) begin set_char(3, 8'h5A); set_char(0, 8'h5A); end
      if (c == 1) begin set_char(3, NL);    set_char(0, NL);    end
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL rr_wrap cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && first_id < 0) first_id = int'(out_id);
      tick();
    end
    compared++;
    if (first_id != 0) begin
      failed++;
      $display("FAIL rr_wrap_first got=%0d exp=0", first_id);
    end
  endtask

  task automatic test_block();
    logic [7:0] got [$];
    logic glast [$];
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      set_char(1, 8'(8'h61 + c));
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL block_fill cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      tick();
    end
    idle_inputs();
    compared++;
    if (char_ready !== 4'b1101) begin
      failed++;
      $display("FAIL block_full_ready got=%b exp=1101", char_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL block_drain cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        glast.push_back(out_last);
      end
      tick();
    end
    compared++;
    if (got.size() != 16) begin
      failed++;
      $display("FAIL block_count got=%0d exp=16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        compared++;
        if ({got[i], glast[i]} !== {8'(8'h61 + i), (i == 15)}) begin
          failed++;
          $display("FAIL block_byte%0d got=%h/%0d exp=%h/%0d", i, got[i], glast[i], 8'(8'h61 + i), (i == 15));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] msg [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] got [$];
    int nlast = 0;
    bit prev_stall = 1'b0;
    logic [11:0] prev_out = '0;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      idle_inputs();
      if (c < 5) set_char(0, msg[c]);
      out_ready = (c < 5) ? 1'b1 : pat[(c - 5) % 4];
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL bp cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (prev_stall) begin
        compared++;
        if ({out_valid, out_data, out_id, out_last} !== prev_out) begin
          failed++;
          $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, {out_valid, out_data, out_id, out_last}, prev_out);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_id, out_last};
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) nlast++;
      end
      tick();
    end
    compared++;
    if (got.size() != 5 || nlast != 1) begin
      failed++;
      $display("FAIL bp_count got=%0d/%0d exp=5/1", got.size(), nlast);
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (got[i] !== msg[i]) begin
          failed++;
          $display("FAIL bp_byte%0d got=%h exp=%h", i, got[i], msg[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [3] = '{8'h78, 8'h79, 8'h0A};
    logic [7:0] got [$];
    int nlast = 0;
    int bad_last = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      idle_inputs();
      if (c < 12) set_char(2, msg[c % 3]);
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) nlast++;
        if (out_last != (out_data == NL)) bad_last++;
      end
      tick();
    end
    compared++;
    if (got.size() != 12 || nlast != 4 || bad_last != 0) begin
      failed++;
      $display("FAIL b2b_lines got=%0d/%0d/%0d exp=12/4/0", got.size(), nlast, bad_last);
    end else begin
      for (int i = 0; i < 12; i++) begin
        compared++;
        if (got[i] !== msg[i % 3]) begin
          failed++;
          $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], msg[i % 3]);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] msg [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h0A};
    int npop = 0;
    int nvalid = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      idle_inputs();
      if (c < 8) set_char(3, msg[c]);
      if (c < 2) set_char(0, 8'h71);
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && out_ready) npop++;
      tick();
      if (npop == 2) break;
    end
    compared++;
    if (npop != 2) begin
      failed++;
      $display("FAIL rst_mid_timeout got=%0d exp=2", npop);
    end
    idle_inputs();
    #2;
    arst = 1'b1;
    #1;
    model_reset();
    compared++;
    if ({busy, out_valid, out_last, out_id, out_data, char_ready} !== 17'h0000F) begin
      failed++;
      $display("FAIL rst_mid_async got=%h exp=0000f", dut_vec());
    end
    @(negedge clk);
    arst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid) nvalid++;
      tick();
    end
    compared++;
    if (nvalid != 0) begin
      failed++;
      $display("FAIL rst_mid_leftover got=%0d exp=0", nvalid);
    end
  endtask

  task automatic test_random();
    int nlines = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_char(r, ($urandom_range(0, 11) == 0) ? NL : 8'(8'h61 + $urandom_range(0, 25)));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      model_outputs();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (out_valid && out_ready && out_last) nlines++;
      tick();
    end
    compared++;
    if (nlines < 50) begin
      failed++;
      $display("FAIL random_progress got=%0d exp>=50", nlines);
    end
  endtask

  initial begin
    arst       = 1'b1;
    char_valid = '0;
    char_data  = '0;
    out_ready  = 1'b0;
    model_reset();
    test_reset();
    test_hi_line();
    test_round_robin();
    test_block();
    test_backpressure();
    test_back_to_back();
    test_reset_midline();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/printf_line_arbiter.md
# printf_line_arbiter

Line-granular arbiter that shares one printf character sink between `N_REQ` requesters, typically one per core, so that text lines from different cores never interleave. Each requester pushes bytes into a private FIFO. The arbiter grants the sink to one requester at a time, round-robin, and drains a whole line (up to and including `NEWLINE`) before re-arbitrating. It sits between the per-core printf write paths and the simulation printf sink adapter.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, at least 2.
- `BUF_DEPTH`, 16: per-requester FIFO depth; must be a power of 2, at least 4.
- `NEWLINE`, 8'h0A: line-terminator byte.

Ports:
- `clk` in 1: clock. One clock domain.
- `arst` in 1: reset, asynchronous and active-high.
- `char_valid` in `N_REQ`: per-requester byte valid.
- `char_data` in `N_REQ*8`: per-requester byte; requester i uses bits [8i+7:8i].
- `char_ready` out `N_REQ`: per-requester FIFO not full.
- `out_valid` out 1: byte valid toward the sink.
- `out_data` out 8: byte.
- `out_id` out `$clog2(N_REQ)`: index of the granted requester.
- `out_last` out 1: this byte ends the current grant.
- `out_ready` in 1: sink accepts the byte.
- `busy` out 1: state is DRAIN.

## Operation
- Per-requester FIFO i:
  - registered occupancy `cnt_i`, width `$clog2(BUF_DEPTH)+1`.
  - registered newline count `nl_i`, same width.
  - Push when `char_valid[i] && char_ready[i]`. A pushed byte equal to `NEWLINE` increments `nl_i`; a popped byte equal to `NEWLINE` decrements it. Push and pop in the same cycle apply both updates.
- `char_ready[i] = (cnt_i != BUF_DEPTH)`. It is a function of registered state only and never depends on `char_valid`.
- Requester i is eligible when `nl_i != 0` (a complete line is buffered) or `cnt_i == BUF_DEPTH` (FIFO full, so it is flushed to avoid deadlock).
- IDLE state:
  - Select the first eligible requester scanning from `rr_ptr` upward, modulo `N_REQ`.
  - If one is found: register `grant` and its mode, then move to DRAIN. Mode is LINE if `nl != 0`, otherwise BLOCK. Clear `sent_cnt`.
  - If none is found: stay in IDLE.
- DRAIN state:
  - `out_valid = (cnt_grant != 0)`, `out_data` = head of the FIFO, `out_id = grant`.
  - Pop on `out_valid && out_ready`.
  - `out_last = out_valid && (LINE ? out_data == NEWLINE : sent_cnt == BUF_DEPTH-1)`.
  - When the popped byte has `out_last` set: go to IDLE and set `rr_ptr = grant+1` (wraps to 0 after `N_REQ-1`).
  - In BLOCK mode, `sent_cnt` increments per pop and exactly `BUF_DEPTH` bytes are sent. Bytes pushed by the granted requester during DRAIN may be sent in the same grant.
- Outside DRAIN, `out_valid`, `out_last` and `out_id` are 0 and `out_data` is 0.
- Requesters that are not granted continue to push freely during DRAIN.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant` 0, all `cnt_i` and `nl_i` 0, `sent_cnt` 0.
  - `char_ready` all 1, `out_valid` 0, `out_last` 0, `out_id` 0, `out_data` 0, `busy` 0.
- `arst` mid-operation discards every buffered byte and any partial grant immediately.
- Latency: a `NEWLINE` accepted at edge E0 makes the requester eligible after E0. An IDLE grant registers at E1, so `out_valid` rises after E1, with no sink backpressure and no competing grant.
- Throughput is one byte per cycle in DRAIN while `out_ready` is high. There is exactly one IDLE cycle between consecutive grants.
- `out_valid`, `out_data`, `out_id` and `out_last` hold stable while `out_valid && !out_ready`.
- A full FIFO that is also granted: the pop frees a slot, but `char_ready` rises only after the edge that performs the pop.
- Simultaneous newline completion on several requesters: the strict round-robin order from `rr_ptr` decides the grant.

## Test plan
- Reset, then requester 0 sends "hi\n" with `out_ready`=1. Required: `out_data` 68,69,0A; `out_id`=0; `out_last` only on 0A; `out_valid` rises 2 cycles after the 0A push.
- Requesters 0–3 each push "A\n" in the same cycle. Required: lines emitted with `out_id` 0,1,2,3, each separated by one idle cycle; `rr_ptr` ends at 0.
- Requester 1 pushes 16 bytes with no newline (`BUF_DEPTH`=16). Required: `char_ready[1]`=0 after the 16th push; BLOCK grant sends 16 bytes; `out_last` on the 16th byte.
- `out_ready` toggles 1,0,0,1 during a 5-byte line. Required: outputs held stable while stalled; all 5 bytes delivered in order, no duplicates.
- Requester 2 keeps pushing "xy\n" while requester 2 is draining. Required: `nl` counts stay consistent; each line emitted with exactly one `out_last`.
- Assert `arst` midway through a line from requester 3. Required: `out_valid`=0 immediately; `char_ready` all 1; no leftover bytes are ever emitted afterwards.
